// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: default widths, the hardwired-zero register
// index and the encodings of the write-back source select.
package pipeline_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;

   localparam int REG_ZERO = 0;

   localparam logic WB_SEL_MEM = 1'b1;
   localparam logic WB_SEL_ALU = 1'b0;

   typedef enum logic {
      WB_FROM_ALU = 1'b0,
      WB_FROM_MEM = 1'b1
   } wb_src_e;

endpackage : pipeline_pkg

// File: rtl/banco_registros.sv
// Integer register storage: one synchronous write port, two combinational
// read ports, register 0 reads as zero, synchronous clear of the whole array.
module banco_registros
   import pipeline_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              reloj,
   input  logic              reset,
   input  logic              we,
   input  logic [ADDR_W-1:0] wr_idx,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd1_idx,
   input  logic [ADDR_W-1:0] rd2_idx,
   output logic [DATA_W-1:0] rd1_data,
   output logic [DATA_W-1:0] rd2_data
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] IDX_ZERO = ADDR_W'(REG_ZERO);

   logic [DATA_W-1:0] registro [DEPTH];

   // Reset has priority, so a write landing on a reset edge is dropped.
   always_ff @(posedge reloj) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            registro[i] <= '0;
         end
      end else if (we && (wr_idx != IDX_ZERO)) begin
         registro[wr_idx] <= wr_data;
      end
   end

   always_comb begin
      rd1_data = (rd1_idx == IDX_ZERO) ? '0 : registro[rd1_idx];
      rd2_data = (rd2_idx == IDX_ZERO) ? '0 : registro[rd2_idx];
   end

endmodule : banco_registros

// File: rtl/wb_regfile.sv
// Write-back stage: selects load data or ALU result, commits it to the
// register file and bypasses the same-cycle write onto the decode read ports.
module wb_regfile
   import pipeline_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              reloj,
   input  logic              resetWB,
   input  logic              DIR_WB,
   input  logic              REG_WR,
   input  logic [DATA_W-1:0] DO_wb,
   input  logic [DATA_W-1:0] DIR_wb,
   input  logic [ADDR_W-1:0] Y_MUX_wb,
   input  logic [ADDR_W-1:0] RS_id,
   input  logic [ADDR_W-1:0] RT_id,
   output logic [DATA_W-1:0] RD1,
   output logic [DATA_W-1:0] RD2,
   output logic [DATA_W-1:0] WB_dato
);

   localparam logic [ADDR_W-1:0] IDX_ZERO = ADDR_W'(REG_ZERO);

   logic [DATA_W-1:0] rd1_store;
   logic [DATA_W-1:0] rd2_store;
   logic              commit;

   always_comb begin
      WB_dato = (DIR_WB == WB_SEL_MEM) ? DO_wb : DIR_wb;
   end

   banco_registros #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_banco (
      .reloj    (reloj),
      .reset    (resetWB),
      .we       (REG_WR),
      .wr_idx   (Y_MUX_wb),
      .wr_data  (WB_dato),
      .rd1_idx  (RS_id),
      .rd2_idx  (RT_id),
      .rd1_data (rd1_store),
      .rd2_data (rd2_store)
   );

   // A write only bypasses when it will actually commit, which keeps
   // register 0 and reset cycles out of the forwarding path.
   always_comb begin
      commit = !resetWB && REG_WR && (Y_MUX_wb != IDX_ZERO);
      RD1    = (commit && (Y_MUX_wb == RS_id)) ? WB_dato : rd1_store;
      RD2    = (commit && (Y_MUX_wb == RT_id)) ? WB_dato : rd2_store;
   end

endmodule : wb_regfile

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: reset clear, bypass, source select,
// register 0, reset during a write, disabled writes and back-to-back writes.
module tb_wb_regfile;

   logic        reloj = 1'b0;
   logic        resetWB = 1'b0;
   logic        DIR_WB = 1'b0;
   logic        REG_WR = 1'b0;
   logic [31:0] DO_wb = '0;
   logic [31:0] DIR_wb = '0;
   logic [4:0]  Y_MUX_wb = '0;
   logic [4:0]  RS_id = '0;
   logic [4:0]  RT_id = '0;
   logic [31:0] RD1;
   logic [31:0] RD2;
   logic [31:0] WB_dato;

   int checks = 0;
   int errors = 0;

   always #5 reloj = ~reloj;

   wb_regfile dut (
      .reloj    (reloj),
      .resetWB  (resetWB),
      .DIR_WB   (DIR_WB),
      .REG_WR   (REG_WR),
      .DO_wb    (DO_wb),
      .DIR_wb   (DIR_wb),
      .Y_MUX_wb (Y_MUX_wb),
      .RS_id    (RS_id),
      .RT_id    (RT_id),
      .RD1      (RD1),
      .RD2      (RD2),
      .WB_dato  (WB_dato)
   );

   // Advance one rising edge and step 1 ns past it before driving again.
   task automatic tick();
      @(posedge reloj);
      #1;
   endtask

   task automatic write_reg(input logic [4:0] idx, input logic [31:0] val);
      REG_WR = 1'b1; DIR_WB = 1'b0; DIR_wb = val; Y_MUX_wb = idx;
      tick();
      REG_WR = 1'b0;
   endtask

   task automatic test_reset();
      resetWB = 1'b1; REG_WR = 1'b0; DIR_WB = 1'b0; DO_wb = '0; DIR_wb = '0;
      tick();
      resetWB = 1'b0;
      for (int i = 0; i < 32; i++) begin
         RS_id = 5'(i); RT_id = 5'(31 - i);
         #1;
         checks++;
         if (RD1 !== 32'h0) begin
            errors++; $display("[TB] FAIL reset_rd1 idx %0d got %h expected %h", i, RD1, 32'h0);
         end
         checks++;
         if (RD2 !== 32'h0) begin
            errors++; $display("[TB] FAIL reset_rd2 idx %0d got %h expected %h", 31 - i, RD2, 32'h0);
         end
      end
      checks++;
      if (WB_dato !== 32'h0) begin
         errors++; $display("[TB] FAIL reset_wbdato got %h expected %h", WB_dato, 32'h0);
      end
   endtask

   task automatic test_bypass();
      REG_WR = 1'b1; DIR_WB = 1'b0; DIR_wb = 32'hDEADBEEF; DO_wb = 32'h0BADF00D;
      Y_MUX_wb = 5'd5; RS_id = 5'd5; RT_id = 5'd6;
      #1;
      checks++;
      if (RD1 !== 32'hDEADBEEF) begin
         errors++; $display("[TB] FAIL bypass_rd1 got %h expected %h", RD1, 32'hDEADBEEF);
      end
      checks++;
      if (RD2 !== 32'h0) begin
         errors++; $display("[TB] FAIL bypass_rd2_other got %h expected %h", RD2, 32'h0);
      end
      checks++;
      if (WB_dato !== 32'hDEADBEEF) begin
         errors++; $display("[TB] FAIL bypass_wbdato got %h expected %h", WB_dato, 32'hDEADBEEF);
      end
      tick();
      REG_WR = 1'b0; DIR_wb = 32'h0;
      #1;
      checks++;
      if (RD1 !== 32'hDEADBEEF) begin
         errors++; $display("[TB] FAIL bypass_stored got %h expected %h", RD1, 32'hDEADBEEF);
      end
   endtask

   task automatic test_mem_select();
      REG_WR = 1'b1; DIR_WB = 1'b1; DO_wb = 32'h12345678; DIR_wb = 32'hFFFFFFFF;
      Y_MUX_wb = 5'd9; RS_id = 5'd1; RT_id = 5'd9;
      #1;
      checks++;
      if (WB_dato !== 32'h12345678) begin
         errors++; $display("[TB] FAIL memsel_wbdato got %h expected %h", WB_dato, 32'h12345678);
      end
      checks++;
      if (RD2 !== 32'h12345678) begin
         errors++; $display("[TB] FAIL memsel_bypass_rd2 got %h expected %h", RD2, 32'h12345678);
      end
      tick();
      REG_WR = 1'b0; DIR_WB = 1'b0; RS_id = 5'd9;
      #1;
      checks++;
      if (RD1 !== 32'h12345678) begin
         errors++; $display("[TB] FAIL memsel_stored got %h expected %h", RD1, 32'h12345678);
      end
      checks++;
      if (WB_dato !== 32'hFFFFFFFF) begin
         errors++; $display("[TB] FAIL alusel_wbdato got %h expected %h", WB_dato, 32'hFFFFFFFF);
      end
   endtask

   task automatic test_zero_reg();
      REG_WR = 1'b1; DIR_WB = 1'b0; DIR_wb = 32'hAAAA5555; Y_MUX_wb = 5'd0;
      RS_id = 5'd0; RT_id = 5'd0;
      #1;
      checks++;
      if (RD1 !== 32'h0) begin
         errors++; $display("[TB] FAIL zero_rd1_same got %h expected %h", RD1, 32'h0);
      end
      checks++;
      if (RD2 !== 32'h0) begin
         errors++; $display("[TB] FAIL zero_rd2_same got %h expected %h", RD2, 32'h0);
      end
      checks++;
      if (WB_dato !== 32'hAAAA5555) begin
         errors++; $display("[TB] FAIL zero_wbdato got %h expected %h", WB_dato, 32'hAAAA5555);
      end
      tick();
      REG_WR = 1'b0;
      #1;
      checks++;
      if (RD1 !== 32'h0) begin
         errors++; $display("[TB] FAIL zero_rd1_after got %h expected %h", RD1, 32'h0);
      end
      checks++;
      if (RD2 !== 32'h0) begin
         errors++; $display("[TB] FAIL zero_rd2_after got %h expected %h", RD2, 32'h0);
      end
   endtask

   task automatic test_reset_mid();
      write_reg(5'd3, 32'h11);
      resetWB = 1'b1; REG_WR = 1'b1; DIR_WB = 1'b0; DIR_wb = 32'h22; Y_MUX_wb = 5'd3;
      RS_id = 5'd3; RT_id = 5'd5;
      #1;
      checks++;
      if (RD1 !== 32'h11) begin
         errors++; $display("[TB] FAIL rstmid_nobypass got %h expected %h", RD1, 32'h11);
      end
      tick();
      resetWB = 1'b0; REG_WR = 1'b0;
      #1;
      checks++;
      if (RD1 !== 32'h0) begin
         errors++; $display("[TB] FAIL rstmid_reg3 got %h expected %h", RD1, 32'h0);
      end
      checks++;
      if (RD2 !== 32'h0) begin
         errors++; $display("[TB] FAIL rstmid_reg5 got %h expected %h", RD2, 32'h0);
      end
   endtask

   task automatic test_no_write();
      write_reg(5'd7, 32'h99);
      REG_WR = 1'b0; DIR_WB = 1'b0; DIR_wb = 32'h55; Y_MUX_wb = 5'd7;
      RS_id = 5'd7; RT_id = 5'd7;
      #1;
      checks++;
      if (RD1 !== 32'h99) begin
         errors++; $display("[TB] FAIL nowr_rd1 got %h expected %h", RD1, 32'h99);
      end
      tick();
      #1;
      checks++;
      if (RD2 !== 32'h99) begin
         errors++; $display("[TB] FAIL nowr_kept got %h expected %h", RD2, 32'h99);
      end
   endtask

   task automatic test_back_to_back();
      write_reg(5'd12, 32'h0000000A);
      REG_WR = 1'b1; DIR_WB = 1'b0; DIR_wb = 32'h0000000B; Y_MUX_wb = 5'd12;
      RS_id = 5'd12; RT_id = 5'd12;
      #1;
      checks++;
      if (RD1 !== 32'h0000000B) begin
         errors++; $display("[TB] FAIL b2b_rd1_bypass got %h expected %h", RD1, 32'h0000000B);
      end
      checks++;
      if (RD2 !== 32'h0000000B) begin
         errors++; $display("[TB] FAIL b2b_rd2_bypass got %h expected %h", RD2, 32'h0000000B);
      end
      tick();
      DIR_wb = 32'hC0FFEE00; Y_MUX_wb = 5'd13; RS_id = 5'd12; RT_id = 5'd13;
      #1;
      checks++;
      if (RD1 !== 32'h0000000B) begin
         errors++; $display("[TB] FAIL b2b_last_wins got %h expected %h", RD1, 32'h0000000B);
      end
      checks++;
      if (RD2 !== 32'hC0FFEE00) begin
         errors++; $display("[TB] FAIL b2b_rd2_other got %h expected %h", RD2, 32'hC0FFEE00);
      end
      tick();
      REG_WR = 1'b0; RS_id = 5'd13; RT_id = 5'd12;
      #1;
      checks++;
      if (RD1 !== 32'hC0FFEE00) begin
         errors++; $display("[TB] FAIL b2b_reg13 got %h expected %h", RD1, 32'hC0FFEE00);
      end
      checks++;
      if (RD2 !== 32'h0000000B) begin
         errors++; $display("[TB] FAIL b2b_reg12 got %h expected %h", RD2, 32'h0000000B);
      end
   endtask

   initial begin
      #1;
      test_reset();
      test_bypass();
      test_mem_select();
      test_zero_reg();
      test_reset_mid();
      test_no_write();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_wb_regfile
